// File: rtl/switch_mcu_pkg.sv
// Shared definitions for the switch MCU I-type decode/sequence slice:
// opcode and funct codes, op-flag bundle and sequencer state encoding.
package switch_mcu_pkg;

   // Major opcodes (RV32I)
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // OP-IMM funct3 codes
   localparam logic [2:0] F3_ADDI  = 3'b000;
   localparam logic [2:0] F3_SLLI  = 3'b001;
   localparam logic [2:0] F3_SLTI  = 3'b010;
   localparam logic [2:0] F3_SLTIU = 3'b011;
   localparam logic [2:0] F3_XORI  = 3'b100;
   localparam logic [2:0] F3_SRXI  = 3'b101;
   localparam logic [2:0] F3_ORI   = 3'b110;
   localparam logic [2:0] F3_ANDI  = 3'b111;

   // Shift funct7 codes
   localparam logic [6:0] F7_NORMAL = 7'b0000000;
   localparam logic [6:0] F7_SRA    = 7'b0100000;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_RETIRE = 2'd2,
      ST_SKIP   = 2'd3
   } state_t;

   // One-hot op flags for the I-type execute stage
   typedef struct packed {
      logic addi;
      logic slti;
      logic sltiu;
      logic xori;
      logic ori;
      logic andi;
      logic slli;
      logic srli;
      logic srai;
   } op_flags_t;

endpackage

// File: rtl/switch_mcu_dec_type_i.sv
// Combinational OP-IMM decoder: instruction word -> one-hot op flags and a
// legal bit. Flags are all zero whenever the word is not a legal OP-IMM.
import switch_mcu_pkg::*;

module switch_mcu_dec_type_i #(
   parameter logic [6:0] OPC_OP_IMM_SEL = OPC_OP_IMM
) (
   input  logic [31:0] instr,
   output op_flags_t   flags,
   output logic        legal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Decode funct3/funct7 into one flag; shift forms require an exact funct7
   always_comb begin
      flags = '0;
      legal = 1'b0;
      if (opcode == OPC_OP_IMM_SEL) begin
         unique case (funct3)
            F3_ADDI:  begin flags.addi  = 1'b1; legal = 1'b1; end
            F3_SLTI:  begin flags.slti  = 1'b1; legal = 1'b1; end
            F3_SLTIU: begin flags.sltiu = 1'b1; legal = 1'b1; end
            F3_XORI:  begin flags.xori  = 1'b1; legal = 1'b1; end
            F3_ORI:   begin flags.ori   = 1'b1; legal = 1'b1; end
            F3_ANDI:  begin flags.andi  = 1'b1; legal = 1'b1; end
            F3_SLLI: begin
               if (funct7 == F7_NORMAL) begin
                  flags.slli = 1'b1;
                  legal      = 1'b1;
               end
            end
            F3_SRXI: begin
               if (funct7 == F7_NORMAL) begin
                  flags.srli = 1'b1;
                  legal      = 1'b1;
               end else if (funct7 == F7_SRA) begin
                  flags.srai = 1'b1;
                  legal      = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/switch_mcu_id_type_i_seq.sv
// Decode and sequencing stage in front of the I-type (OP-IMM) execute stage.
// Accepts one instruction, holds its decoded fields for the execute window
// and drives the cycle counter the execute stage keys on.
//
// Optional feature macro: SWITCH_MCU_ILLEGAL_TRAP_EN adds out_illegal, a
// one-cycle pulse alongside done for words that are not legal OP-IMM.
//
// Handshake: a word transfers on a cycle where in_instr_valid and
// out_instr_ready are both 1; in_instr is sampled only on that cycle.
// valid while ready=0 is ignored and the sender must hold the word.
import switch_mcu_pkg::*;

module switch_mcu_id_type_i_seq #(
   parameter int         EXEC_CYCLES = 5,
   parameter logic [6:0] OPC_OP_IMM  = 7'b0010011
) (
   input  logic        in_clk,
   input  logic        in_rst,
   input  logic        in_instr_valid,
   input  logic [31:0] in_instr,
   output logic        out_instr_ready,
   output logic [3:0]  out_cycle_cnt,
   output logic        out_en,
   output logic        out_addi,
   output logic        out_slti,
   output logic        out_sltiu,
   output logic        out_xori,
   output logic        out_ori,
   output logic        out_andi,
   output logic        out_slli,
   output logic        out_srli,
   output logic        out_srai,
   output logic [11:0] out_imm_type_i,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rd,
   output logic        out_done,
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
   output logic        out_illegal,
`endif
   output logic [1:0]  out_dbg_state
);

   if (EXEC_CYCLES > 15 || EXEC_CYCLES < 4) begin : g_bad_exec_cycles
      $error("EXEC_CYCLES must be in 4..15");
   end

   localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES);

   op_flags_t  dec_flags;
   logic       dec_legal;

   state_t     state_q;
   op_flags_t  flags_q;
   logic       ready_q;
   logic [3:0] cnt_q;
   logic       en_q;
   logic [11:0] imm_q;
   logic [4:0] rs1_q;
   logic [4:0] rd_q;
   logic       done_q;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
   logic       illegal_q;
`endif

   switch_mcu_dec_type_i #(
      .OPC_OP_IMM_SEL (OPC_OP_IMM)
   ) u_dec (
      .instr (in_instr),
      .flags (dec_flags),
      .legal (dec_legal)
   );

   // Sequencer: IDLE -> EXEC -> RETIRE -> IDLE, IDLE -> SKIP -> IDLE; all outputs registered
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         flags_q   <= '0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rd_q      <= '0;
         done_q    <= 1'b0;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (in_instr_valid && ready_q) begin
                  ready_q <= 1'b0;
                  if (dec_legal) begin
                     state_q <= ST_EXEC;
                     cnt_q   <= 4'd1;
                     en_q    <= 1'b1;
                     flags_q <= dec_flags;
                     imm_q   <= in_instr[31:20];
                     rs1_q   <= in_instr[19:15];
                     rd_q    <= in_instr[11:7];
                  end else begin
                     state_q   <= ST_SKIP;
                     done_q    <= 1'b1;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
                     illegal_q <= 1'b1;
`endif
                  end
               end
            end
            ST_EXEC: begin
               if (cnt_q == EXEC_LAST) begin
                  state_q <= ST_RETIRE;
                  cnt_q   <= '0;
                  en_q    <= 1'b0;
                  flags_q <= '0;
                  imm_q   <= '0;
                  rs1_q   <= '0;
                  rd_q    <= '0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_RETIRE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            ST_SKIP: begin
               state_q   <= ST_IDLE;
               done_q    <= 1'b0;
               ready_q   <= 1'b1;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
               illegal_q <= 1'b0;
`endif
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               cnt_q   <= '0;
               en_q    <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_instr_ready = ready_q;
   assign out_cycle_cnt   = cnt_q;
   assign out_en          = en_q;
   assign out_addi        = flags_q.addi;
   assign out_slti        = flags_q.slti;
   assign out_sltiu       = flags_q.sltiu;
   assign out_xori        = flags_q.xori;
   assign out_ori         = flags_q.ori;
   assign out_andi        = flags_q.andi;
   assign out_slli        = flags_q.slli;
   assign out_srli        = flags_q.srli;
   assign out_srai        = flags_q.srai;
   assign out_imm_type_i  = imm_q;
   assign out_rs1         = rs1_q;
   assign out_rd          = rd_q;
   assign out_done        = done_q;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
   assign out_illegal     = illegal_q;
`endif
   assign out_dbg_state   = state_q;

endmodule

// File: tb/tb_switch_mcu_id_type_i_seq.sv
// Directed bench for switch_mcu_id_type_i_seq (default EXEC_CYCLES=5).
// Inputs change and outputs are observed on the falling clock edge.
module tb_switch_mcu_id_type_i_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] instr = '0;
   logic        ready, en, done;
   logic [3:0]  cnt;
   logic        addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
   logic [11:0] imm;
   logic [4:0]  rs1, rd;
   logic [1:0]  dbg_state;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
   logic        illegal;
`endif
   logic [8:0]  flags;

   int total  = 0;
   int passed = 0;

   assign flags = {addi, slti, sltiu, xori, ori, andi, slli, srli, srai};

   switch_mcu_id_type_i_seq dut (
      .in_clk          (clk),
      .in_rst          (rst),
      .in_instr_valid  (valid),
      .in_instr        (instr),
      .out_instr_ready (ready),
      .out_cycle_cnt   (cnt),
      .out_en          (en),
      .out_addi        (addi),
      .out_slti        (slti),
      .out_sltiu       (sltiu),
      .out_xori        (xori),
      .out_ori         (ori),
      .out_andi        (andi),
      .out_slli        (slli),
      .out_srli        (srli),
      .out_srai        (srai),
      .out_imm_type_i  (imm),
      .out_rs1         (rs1),
      .out_rd          (rd),
      .out_done        (done),
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
      .out_illegal     (illegal),
`endif
      .out_dbg_state   (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   // Present a word for one handshake cycle; returns at the negedge showing the result
   task automatic accept(input logic [31:0] w);
      valid = 1'b1;
      instr = w;
      step();
      valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; valid = 1'b0; instr = '0;
      repeat (2) step();
      total++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else passed++;
      total++; if (cnt !== 4'd0) $display("FAIL reset_cnt got=%0d exp=0", cnt); else passed++;
      total++; if ({en, done, flags} !== 11'd0) $display("FAIL reset_ctl got=%h exp=0", {en, done, flags}); else passed++;
      total++; if ({imm, rs1, rd} !== 22'd0) $display("FAIL reset_fields got=%h exp=0", {imm, rs1, rd}); else passed++;
      rst = 1'b1;
      step();
      total++; if (ready !== 1'b1 || dbg_state !== 2'd0) $display("FAIL post_reset_idle got=%b/%0d exp=1/0", ready, dbg_state); else passed++;
   endtask

   // Run a legal word through its full window and check flags, fields, count and retire
   task automatic run_exec(input string name, input logic [31:0] w, input logic [8:0] exp_flags,
                           input logic [11:0] exp_imm, input logic [4:0] exp_rs1, input logic [4:0] exp_rd);
      accept(w);
      total++; if (cnt !== 4'd1 || en !== 1'b1 || ready !== 1'b0) $display("FAIL %s_first cnt=%0d en=%b ready=%b exp 1/1/0", name, cnt, en, ready); else passed++;
      total++; if (flags !== exp_flags) $display("FAIL %s_flags got=%b exp=%b", name, flags, exp_flags); else passed++;
      total++; if ({imm, rs1, rd} !== {exp_imm, exp_rs1, exp_rd}) $display("FAIL %s_fields got=%h/%0d/%0d exp=%h/%0d/%0d", name, imm, rs1, rd, exp_imm, exp_rs1, exp_rd); else passed++;
      for (int k = 2; k <= 5; k++) begin
         step();
         total++; if (cnt !== 4'(k) || en !== 1'b1 || flags !== exp_flags || imm !== exp_imm || done !== 1'b0)
            $display("FAIL %s_cnt%0d cnt=%0d en=%b flags=%b imm=%h done=%b", name, k, cnt, en, flags, imm, done); else passed++;
      end
      step();
      total++; if (done !== 1'b1 || cnt !== 4'd0 || en !== 1'b0 || ready !== 1'b0) $display("FAIL %s_retire done=%b cnt=%0d en=%b ready=%b exp 1/0/0/0", name, done, cnt, en, ready); else passed++;
      total++; if ({flags, imm, rs1, rd} !== 31'd0) $display("FAIL %s_retire_clear got=%h exp=0", name, {flags, imm, rs1, rd}); else passed++;
      step();
      total++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL %s_idle ready=%b done=%b exp 1/0", name, ready, done); else passed++;
   endtask

   task automatic test_addi();
      run_exec("addi", 32'hFFF18293, 9'h100, 12'hFFF, 5'd3, 5'd5);
   endtask

   task automatic test_srai();
      run_exec("srai", 32'h40715093, 9'h001, 12'h407, 5'd2, 5'd1);
   endtask

   // Non-executing word: one SKIP cycle with done, never en
   task automatic run_skip(input string name, input logic [31:0] w);
      accept(w);
      total++; if (done !== 1'b1 || en !== 1'b0 || cnt !== 4'd0 || ready !== 1'b0) $display("FAIL %s_skip done=%b en=%b cnt=%0d ready=%b exp 1/0/0/0", name, done, en, cnt, ready); else passed++;
      total++; if (flags !== 9'd0) $display("FAIL %s_skip_flags got=%b exp=0", name, flags); else passed++;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
      total++; if (illegal !== 1'b1) $display("FAIL %s_illegal got=%b exp=1", name, illegal); else passed++;
`endif
      step();
      total++; if (ready !== 1'b1 || done !== 1'b0 || en !== 1'b0) $display("FAIL %s_skip_idle ready=%b done=%b en=%b exp 1/0/0", name, ready, done, en); else passed++;
`ifdef SWITCH_MCU_ILLEGAL_TRAP_EN
      total++; if (illegal !== 1'b0) $display("FAIL %s_illegal_end got=%b exp=0", name, illegal); else passed++;
`endif
   endtask

   task automatic test_bad_shift();
      run_skip("bad_srai", 32'h20715093);
   endtask

   task automatic test_load();
      run_skip("lw", 32'h00012083);
   endtask

   // ori in flight; an addi offered from cnt=3 must wait for ready
   task automatic test_valid_during_exec();
      accept(32'h0F00E393);
      step(); step();
      total++; if (cnt !== 4'd3 || flags !== 9'h010) $display("FAIL hold_cnt3 cnt=%0d flags=%b exp 3/%b", cnt, flags, 9'h010); else passed++;
      valid = 1'b1;
      instr = 32'hFFF18293;
      step(); step();
      total++; if (cnt !== 4'd5 || flags !== 9'h010 || imm !== 12'h0F0 || rd !== 5'd7) $display("FAIL hold_cnt5 cnt=%0d flags=%b imm=%h rd=%0d", cnt, flags, imm, rd); else passed++;
      step();
      total++; if (done !== 1'b1 || ready !== 1'b0) $display("FAIL hold_retire done=%b ready=%b exp 1/0", done, ready); else passed++;
      step();
      total++; if (ready !== 1'b1 || en !== 1'b0) $display("FAIL hold_idle ready=%b en=%b exp 1/0", ready, en); else passed++;
      step();
      valid = 1'b0;
      total++; if (cnt !== 4'd1 || flags !== 9'h100 || imm !== 12'hFFF || rd !== 5'd5) $display("FAIL hold_next cnt=%0d flags=%b imm=%h rd=%0d", cnt, flags, imm, rd); else passed++;
      repeat (6) step();
      total++; if (ready !== 1'b1 || dbg_state !== 2'd0) $display("FAIL hold_drain ready=%b state=%0d exp 1/0", ready, dbg_state); else passed++;
   endtask

   // Asynchronous reset at cnt=2 aborts without a done pulse
   task automatic test_reset_mid_exec();
      int dones;
      accept(32'hFFF18293);
      step();
      total++; if (cnt !== 4'd2) $display("FAIL rst_mid_cnt got=%0d exp=2", cnt); else passed++;
      #2 rst = 1'b0;
      #1;
      total++; if (ready !== 1'b1 || cnt !== 4'd0 || en !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_async ready=%b cnt=%0d en=%b done=%b", ready, cnt, en, done); else passed++;
      total++; if ({flags, imm, rs1, rd} !== 31'd0) $display("FAIL rst_mid_fields got=%h exp=0", {flags, imm, rs1, rd}); else passed++;
      step(); step();
      rst = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done === 1'b1) dones++;
      end
      total++; if (dones !== 0) $display("FAIL rst_mid_no_done got=%0d exp=0", dones); else passed++;
      total++; if (ready !== 1'b1 || en !== 1'b0) $display("FAIL rst_mid_idle ready=%b en=%b exp 1/0", ready, en); else passed++;
   endtask

   // slli, xori, andi streamed with valid held high
   task automatic test_back_to_back();
      logic [31:0] words [3];
      logic [8:0]  exp_f [3];
      logic [11:0] exp_i [3];
      int idx, dones, last_cnt, onehot_bad, windows_ok;
      words = '{32'h00321213, 32'h0552C313, 32'h7FF47493};
      exp_f = '{9'h004, 9'h020, 9'h008};
      exp_i = '{12'h003, 12'h055, 12'h7FF};
      idx = 0; dones = 0; last_cnt = 0; onehot_bad = 0; windows_ok = 0;
      valid = 1'b1;
      instr = words[0];
      for (int cyc = 0; cyc < 60 && dones < 3; cyc++) begin
         step();
         if (en === 1'b1 && $countones(flags) != 1) onehot_bad++;
         if (en !== 1'b1 && flags !== 9'd0) onehot_bad++;
         if (en === 1'b1 && cnt === 4'd1 && idx < 3) begin
            total++; if (flags !== exp_f[idx] || imm !== exp_i[idx]) $display("FAIL b2b_word%0d flags=%b imm=%h exp=%b/%h", idx, flags, imm, exp_f[idx], exp_i[idx]); else passed++;
            idx++;
            if (idx < 3) instr = words[idx];
            else valid = 1'b0;
         end
         if (done === 1'b1) begin
            dones++;
            if (last_cnt == 5) windows_ok++;
         end
         if (en === 1'b1) last_cnt = int'(cnt);
      end
      valid = 1'b0;
      total++; if (idx !== 3) $display("FAIL b2b_starts got=%0d exp=3", idx); else passed++;
      total++; if (dones !== 3) $display("FAIL b2b_dones got=%0d exp=3", dones); else passed++;
      total++; if (windows_ok !== 3) $display("FAIL b2b_full_windows got=%0d exp=3", windows_ok); else passed++;
      total++; if (onehot_bad !== 0) $display("FAIL b2b_onehot got=%0d exp=0", onehot_bad); else passed++;
      step();
      total++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL b2b_idle ready=%b done=%b exp 1/0", ready, done); else passed++;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_srai();
      test_bad_shift();
      test_load();
      test_valid_during_exec();
      test_reset_mid_exec();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
